// File: rtl/formula_nested_sqrt_fsm_if.sv
// Handshake bundle for formula_nested_sqrt_fsm.
// Carries two groups of signals:
//   caller side:  arg_vld/arg_rdy/n_terms/args in, res_vld/res out
//   isqrt side:   isqrt_x_vld/isqrt_x out, isqrt_y_vld/isqrt_y in
// The slave modport is the sequencer's view. The master modport is the
// environment's view: it acts as both the caller and the shared isqrt unit.
interface formula_nested_sqrt_fsm_if #(
  parameter int N_ARGS = 3,
  parameter int W      = 32
);
  localparam int NW = $clog2(N_ARGS + 1);

  logic                arg_vld;
  logic                arg_rdy;
  logic [NW-1:0]       n_terms;
  logic [N_ARGS*W-1:0] args;
  logic                res_vld;
  logic [W-1:0]        res;
  logic                isqrt_x_vld;
  logic [W-1:0]        isqrt_x;
  logic                isqrt_y_vld;
  logic [W/2-1:0]      isqrt_y;

  modport master (
    output arg_vld, n_terms, args, isqrt_y_vld, isqrt_y,
    input  arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
  );

  modport slave (
    input  arg_vld, n_terms, args, isqrt_y_vld, isqrt_y,
    output arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
  );
endinterface

// File: rtl/formula_nested_sqrt_fsm.sv
// Nested square-root sequencer:
//   res = isqrt(args[0] + isqrt(args[1] + ... isqrt(args[n-1])))
// It evaluates the formula from the innermost term outwards, using one
// shared external isqrt unit of arbitrary latency.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  formula_nested_sqrt_fsm_if.slave:
//          arg_vld/arg_rdy/n_terms/args  request handshake; args are latched on accept
//          res_vld/res                   one-cycle result pulse; res holds its value
//          isqrt_x_vld/isqrt_x           request to the isqrt unit
//          isqrt_y_vld/isqrt_y           response from the isqrt unit
//
// state | meaning
// IDLE  | ready for a request, arg_rdy high
// ISSUE | drive one isqrt request for stage idx
// WAIT  | wait for the isqrt result of stage idx
module formula_nested_sqrt_fsm #(
  parameter int N_ARGS = 3,
  parameter int W      = 32
) (
  input logic                      clk,
  input logic                      rst,
  formula_nested_sqrt_fsm_if.slave bus
);
  localparam int NW = $clog2(N_ARGS + 1);
  localparam int IW = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;
  localparam int HW = W / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  arg_q [N_ARGS];
  logic [IW-1:0] idx;
  logic [HW-1:0] acc;
  logic [W-1:0]  res_q;
  logic          res_vld_q;
  logic [NW-1:0] n_clamp;
  logic [IW-1:0] idx_init;
  logic          last_stage;

  // Depth 0 runs as a single term; depths beyond N_ARGS saturate.
  always_comb begin
    n_clamp = bus.n_terms;
    if (bus.n_terms == '0) begin
      n_clamp = NW'(1);
    end else if (bus.n_terms > NW'(N_ARGS)) begin
      n_clamp = NW'(N_ARGS);
    end
  end

  assign idx_init   = IW'(n_clamp - NW'(1));
  assign last_stage = (idx == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.arg_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bus.isqrt_y_vld) state_nxt = last_stage ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  // idx counts down from the innermost term; acc carries the previous
  // stage's root into the next sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ARGS; i++) arg_q[i] <= '0;
      idx       <= '0;
      acc       <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      res_vld_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.arg_vld) begin
            for (int i = 0; i < N_ARGS; i++) arg_q[i] <= bus.args[i*W +: W];
            idx <= idx_init;
            acc <= '0;
          end
        end
        WAIT: begin
          if (bus.isqrt_y_vld) begin
            acc <= bus.isqrt_y;
            if (last_stage) begin
              res_q     <= {{(W-HW){1'b0}}, bus.isqrt_y};
              res_vld_q <= 1'b1;
            end else begin
              idx <= idx - IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.arg_rdy     = (state == IDLE);
  assign bus.isqrt_x_vld = (state == ISSUE);
  // Sum wraps modulo 2^W; forced to zero outside ISSUE so it is never X.
  assign bus.isqrt_x     = (state == ISSUE) ? (arg_q[idx] + {{(W-HW){1'b0}}, acc}) : '0;
  assign bus.res_vld     = res_vld_q;
  assign bus.res         = res_q;
endmodule

// File: tb/tb_formula_nested_sqrt_fsm.sv
module tb_formula_nested_sqrt_fsm;
  localparam int N  = 3;
  localparam int W  = 32;
  localparam int NW = $clog2(N + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  formula_nested_sqrt_fsm_if #(.N_ARGS(N), .W(W)) bus ();

  formula_nested_sqrt_fsm #(.N_ARGS(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // isqrt unit model plus a manual override used by the reset/stray tests
  bit             model_en = 1'b0;
  int             lat_lo = 1;
  int             lat_hi = 1;
  logic           m_y_vld = 1'b0;
  logic [W/2-1:0] m_y = '0;
  logic           man_y_vld = 1'b0;
  logic [W/2-1:0] man_y = '0;
  logic [W-1:0]   xq [$];
  logic [W-1:0]   exp_xq [$];
  logic [W-1:0]   mx;
  int             ml;
  int             res_pulses = 0;
  int             x_pulses = 0;

  assign bus.isqrt_y_vld = m_y_vld | man_y_vld;
  assign bus.isqrt_y     = man_y_vld ? man_y : m_y;

  function automatic logic [W/2-1:0] isqrt_ref(input logic [W-1:0] x);
    longint lo = 0;
    longint hi = (longint'(1) << (W/2)) - 1;
    longint mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(x)) lo = mid;
      else hi = mid - 1;
    end
    return (W/2)'(lo);
  endfunction

  // Formula evaluated directly, innermost term first.
  task automatic ref_model(input int nt, input logic [N*W-1:0] a, output logic [W-1:0] r);
    int n;
    logic [W-1:0] x;
    logic [W/2-1:0] acc;
    n = (nt == 0) ? 1 : ((nt > N) ? N : nt);
    acc = '0;
    exp_xq.delete();
    for (int i = n - 1; i >= 0; i--) begin
      x = a[i*W +: W] + {{(W/2){1'b0}}, acc};
      exp_xq.push_back(x);
      acc = isqrt_ref(x);
    end
    r = {{(W/2){1'b0}}, acc};
  endtask

  always begin
    @(negedge clk);
    if (model_en && bus.isqrt_x_vld === 1'b1) begin
      mx = bus.isqrt_x;
      xq.push_back(mx);
      ml = $urandom_range(lat_hi, lat_lo);
      for (int k = 0; k < ml; k++) begin
        @(negedge clk);
        checks++;
        if (bus.isqrt_x_vld !== 1'b0) begin
          errors++;
          $display("FAIL overlap: isqrt_x_vld=%b with request outstanding, required 0", bus.isqrt_x_vld);
        end
      end
      m_y     = isqrt_ref(mx);
      m_y_vld = 1'b1;
      @(posedge clk);
      #1 m_y_vld = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (bus.res_vld === 1'b1) res_pulses++;
    if (bus.isqrt_x_vld === 1'b1) x_pulses++;
  end

  // Presents a request now, accepts at the next edge, then waits for res_vld.
  // Returns at negedge+1 of the res_vld cycle so a caller can chain back-to-back.
  task automatic do_job(input int nt, input logic [N*W-1:0] a, input bit hold,
                        output logic [W-1:0] r, output int cyc);
    int rp0;
    xq.delete();
    bus.arg_vld = 1'b1;
    bus.n_terms = NW'(nt);
    bus.args    = a;
    @(posedge clk);
    rp0 = res_pulses;
    #1;
    if (!hold) bus.arg_vld = 1'b0;
    cyc = 1;
    forever begin
      @(negedge clk);
      if (bus.res_vld === 1'b1) break;
      if (cyc > 200) begin
        checks++; errors++;
        $display("FAIL job_timeout: no res_vld after %0d cycles, required within 200", cyc);
        break;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (hold) begin
        for (int i = 0; i < N; i++) bus.args[i*W +: W] = $urandom;
        bus.n_terms = NW'($urandom_range(0, 3));
      end
    end
    r = bus.res;
    bus.arg_vld = 1'b0;
    #1;
    checks++;
    if (res_pulses - rp0 !== 1) begin
      errors++;
      $display("FAIL res_vld_count: got %0d pulses, required 1", res_pulses - rp0);
    end
    checks++;
    if (bus.arg_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rdy_with_res: arg_rdy=%b, required 1", bus.arg_rdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.arg_vld = 1'b0;
    bus.n_terms = '0;
    bus.args = '0;
    #12;
    checks++; if (bus.arg_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b, required 1", bus.arg_rdy); end
    checks++; if (bus.res_vld !== 1'b0) begin errors++; $display("FAIL reset_res_vld: got %b, required 0", bus.res_vld); end
    checks++; if (bus.res !== '0) begin errors++; $display("FAIL reset_res: got %0d, required 0", bus.res); end
    checks++; if (bus.isqrt_x_vld !== 1'b0) begin errors++; $display("FAIL reset_x_vld: got %b, required 0", bus.isqrt_x_vld); end
    checks++; if (bus.isqrt_x !== '0) begin errors++; $display("FAIL reset_x: got %h, required 0", bus.isqrt_x); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_depth3();
    logic [W-1:0] r;
    int cyc;
    model_en = 1'b1; lat_lo = 2; lat_hi = 2;
    @(posedge clk); #1;
    do_job(3, {32'd16, 32'd12, 32'd21}, 1'b0, r, cyc);
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL depth3_res: got %0d, required 5", r); end
    checks++; if (cyc !== 10) begin errors++; $display("FAIL depth3_latency: got %0d, required 10", cyc); end
    checks++;
    if (xq.size() !== 3 || xq[0] !== 32'd16 || xq[1] !== 32'd16 || xq[2] !== 32'd25) begin
      errors++; $display("FAIL depth3_xseq: got %p, required 16 16 25", xq);
    end
    repeat (3) @(negedge clk);
    checks++; if (bus.res !== 32'd5) begin errors++; $display("FAIL res_hold: got %0d, required 5", bus.res); end
  endtask

  task automatic test_depth_clamp();
    logic [W-1:0] r;
    int cyc;
    int nts [3] = '{1, 0, 7};
    lat_lo = 1; lat_hi = 1;
    for (int t = 0; t < 2; t++) begin
      @(posedge clk); #1;
      do_job(nts[t], {32'd99, 32'd77, 32'd1000000}, 1'b0, r, cyc);
      checks++; if (r !== 32'd1000) begin errors++; $display("FAIL depth%0d_res: got %0d, required 1000", nts[t], r); end
      checks++; if (cyc !== 3) begin errors++; $display("FAIL depth%0d_latency: got %0d, required 3", nts[t], cyc); end
      checks++;
      if (xq.size() !== 1 || xq[0] !== 32'd1000000) begin
        errors++; $display("FAIL depth%0d_xseq: got %p, required 1000000", nts[t], xq);
      end
    end
    // 7 does not fit the 2-bit field and arrives as 3, the maximum depth.
    @(posedge clk); #1;
    do_job(nts[2], {32'd16, 32'd12, 32'd21}, 1'b0, r, cyc);
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL depth_max_res: got %0d, required 5", r); end
    checks++; if (cyc !== 7) begin errors++; $display("FAIL depth_max_latency: got %0d, required 7", cyc); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] r;
    int cyc;
    lat_lo = 1; lat_hi = 4;
    @(posedge clk); #1;
    do_job(2, {32'd0, 32'd4, 32'hFFFF_FFFE}, 1'b0, r, cyc);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL wrap_res: got %0d, required 0", r); end
    checks++;
    if (xq.size() !== 2 || xq[0] !== 32'd4 || xq[1] !== 32'd0) begin
      errors++; $display("FAIL wrap_xseq: got %p, required 4 0", xq);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r;
    int cyc;
    int rp0;
    lat_lo = 3; lat_hi = 3;
    @(posedge clk); #1;
    do_job(3, {32'd16, 32'd12, 32'd21}, 1'b1, r, cyc);
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL hold_res: got %0d, required 5", r); end
    checks++; if (cyc !== 13) begin errors++; $display("FAIL hold_latency: got %0d, required 13", cyc); end
    do_job(1, {32'd5, 32'd6, 32'd1000000}, 1'b0, r, cyc);
    checks++; if (r !== 32'd1000) begin errors++; $display("FAIL b2b_res: got %0d, required 1000", r); end
    checks++; if (cyc !== 5) begin errors++; $display("FAIL b2b_latency: got %0d, required 5", cyc); end
    model_en = 1'b0;
    rp0 = res_pulses;
    @(posedge clk); #1;
    man_y = 16'd77; man_y_vld = 1'b1;
    @(posedge clk); #1;
    man_y_vld = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (res_pulses !== rp0) begin errors++; $display("FAIL stray_res_vld: got %0d pulses, required 0", res_pulses - rp0); end
    checks++; if (bus.res !== 32'd1000) begin errors++; $display("FAIL stray_res: got %0d, required 1000", bus.res); end
    checks++; if (bus.arg_rdy !== 1'b1) begin errors++; $display("FAIL stray_rdy: got %b, required 1", bus.arg_rdy); end
    checks++; if (bus.isqrt_x_vld !== 1'b0) begin errors++; $display("FAIL stray_x_vld: got %b, required 0", bus.isqrt_x_vld); end
    model_en = 1'b1;
    @(posedge clk); #1;
    do_job(2, {32'd0, 32'd49, 32'd42}, 1'b0, r, cyc);
    checks++; if (r !== 32'd7) begin errors++; $display("FAIL after_stray_res: got %0d, required 7", r); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] r;
    int cyc;
    int rp0;
    model_en = 1'b0;
    @(posedge clk); #1;
    bus.arg_vld = 1'b1; bus.n_terms = NW'(3); bus.args = {32'd16, 32'd12, 32'd21};
    @(posedge clk); #1;
    bus.arg_vld = 1'b0;
    @(negedge clk);
    checks++; if (bus.isqrt_x_vld !== 1'b1 || bus.isqrt_x !== 32'd16) begin
      errors++; $display("FAIL mid_stage1: x_vld=%b x=%0d, required 1 16", bus.isqrt_x_vld, bus.isqrt_x); end
    @(negedge clk);
    man_y = 16'd4; man_y_vld = 1'b1;
    @(posedge clk); #1;
    man_y_vld = 1'b0;
    @(negedge clk);
    checks++; if (bus.isqrt_x_vld !== 1'b1 || bus.isqrt_x !== 32'd16) begin
      errors++; $display("FAIL mid_stage2: x_vld=%b x=%0d, required 1 16", bus.isqrt_x_vld, bus.isqrt_x); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.arg_rdy !== 1'b1) begin errors++; $display("FAIL async_rdy: got %b, required 1", bus.arg_rdy); end
    checks++; if (bus.isqrt_x_vld !== 1'b0) begin errors++; $display("FAIL async_x_vld: got %b, required 0", bus.isqrt_x_vld); end
    checks++; if (bus.res !== '0) begin errors++; $display("FAIL async_res: got %0d, required 0", bus.res); end
    @(negedge clk);
    rst = 1'b0;
    rp0 = res_pulses;
    repeat (2) @(posedge clk);
    #1 man_y = 16'd9; man_y_vld = 1'b1;
    @(posedge clk); #1;
    man_y_vld = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (res_pulses !== rp0) begin errors++; $display("FAIL late_y_res_vld: got %0d pulses, required 0", res_pulses - rp0); end
    checks++; if (bus.res !== '0) begin errors++; $display("FAIL late_y_res: got %0d, required 0", bus.res); end
    checks++; if (bus.arg_rdy !== 1'b1) begin errors++; $display("FAIL late_y_rdy: got %b, required 1", bus.arg_rdy); end
    model_en = 1'b1; lat_lo = 1; lat_hi = 3;
    @(posedge clk); #1;
    do_job(3, {32'd16, 32'd12, 32'd21}, 1'b0, r, cyc);
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL post_reset_res: got %0d, required 5", r); end
  endtask

  task automatic test_random();
    logic [W-1:0] r, exp_r;
    logic [N*W-1:0] a;
    int cyc, nt, n, sum_n, x0, rp0;
    bit bad;
    model_en = 1'b1; lat_lo = 1; lat_hi = 8;
    sum_n = 0;
    x0 = x_pulses;
    rp0 = res_pulses;
    @(posedge clk); #1;
    for (int j = 0; j < 1000; j++) begin
      nt = $urandom_range(0, 3);
      for (int i = 0; i < N; i++)
        a[i*W +: W] = ($urandom_range(0, 1) == 1) ? $urandom : W'($urandom_range(0, 2000));
      ref_model(nt, a, exp_r);
      n = exp_xq.size();
      sum_n += n;
      do_job(nt, a, ($urandom_range(0, 3) == 0), r, cyc);
      checks++;
      if (r !== exp_r) begin
        errors++; $display("FAIL rand_res job %0d: got %0d, required %0d", j, r, exp_r);
      end
      bad = (xq.size() != exp_xq.size());
      if (!bad) for (int i = 0; i < n; i++) if (xq[i] !== exp_xq[i]) bad = 1'b1;
      checks++;
      if (bad) begin
        errors++; $display("FAIL rand_xseq job %0d: got %p, required %p", j, xq, exp_xq);
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
    #1;
    checks++; if (x_pulses - x0 !== sum_n) begin errors++; $display("FAIL rand_x_pulses: got %0d, required %0d", x_pulses - x0, sum_n); end
    checks++; if (res_pulses - rp0 !== 1000) begin errors++; $display("FAIL rand_res_pulses: got %0d, required 1000", res_pulses - rp0); end
  endtask

  initial begin
    test_reset();
    test_depth3();
    test_depth_clamp();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/formula_nested_sqrt_fsm.md
# formula_nested_sqrt_fsm

Parametrised sequencer that computes the nested square-root formula res = isqrt(arg0 + isqrt(arg1 + … isqrt(arg(n-1)))) for a run-time depth n of 1 to N_ARGS terms. It drives a single external isqrt instance through its valid-in/valid-out interface. It adds an input-ready handshake and input latching, so callers may change the arguments while a computation is in flight. It sits between the formula-level datapath and one shared isqrt unit of arbitrary, possibly variable, latency.

## Interface
- N_ARGS, 3, maximum number of nested terms (≥1).
- W, 32, argument/result/sum width; even, ≥4; isqrt result width is W/2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- arg_vld  in  1  request valid; accepted when arg_vld & arg_rdy.
- arg_rdy  out  1  high exactly when in IDLE.
- n_terms  in  $clog2(N_ARGS+1)  requested depth; latched on accept.
- args  in  N_ARGS*W  packed arguments; args[i] occupies bits [i*W +: W]; latched on accept.
- res_vld  out  1  one-cycle pulse, result valid.
- res  out  W  result, zero-extended isqrt output; holds the last value until the next result.
- isqrt_x_vld  out  1  one-cycle request pulse to the isqrt unit.
- isqrt_x  out  W  operand to the isqrt unit.
- isqrt_y_vld  in  1  isqrt result valid.
- isqrt_y  in  W/2  isqrt result.

## Operation
- Registers: state, latched args, depth/index counter idx, accumulator acc (W/2 bits), res, res_vld.
- Depth: n = n_terms clamped. 0 is treated as 1; values > N_ARGS are treated as N_ARGS. args[n-1] is innermost and args[0] outermost.
- IDLE: arg_rdy=1. On arg_vld: latch args, set idx=n-1, acc=0, go to ISSUE.
- ISSUE: isqrt_x_vld=1, isqrt_x = args[idx] + {0, acc}, with the sum taken mod 2^W (wrap, no saturation). Go to WAIT unconditionally.
- WAIT: isqrt_x_vld=0. On isqrt_y_vld:
  - acc <= isqrt_y.
  - If idx==0: res <= {0, isqrt_y}, res_vld <= 1, go to IDLE.
  - Otherwise: idx <= idx-1, go to ISSUE.
- isqrt_x is a function of registers only; it is don't-care outside ISSUE but must not be X (drive 0).
- isqrt_y_vld outside WAIT is ignored and does not change acc, res or state.
- arg_vld while arg_rdy=0 is ignored; no queueing.
- Reset: state=IDLE, res_vld=0, res=0, acc=0, idx=0, isqrt_x_vld=0, arg_rdy=1. Reset takes effect immediately (async), including mid-computation. A late isqrt_y_vld from an aborted job arriving after reset deassert is ignored (state is IDLE).

## Timing
- Accept on edge E0; isqrt_x_vld is high in the cycle after E0.
- Each stage costs L+1 cycles, where L is the isqrt latency from x_vld to y_vld: the next ISSUE is the cycle after y_vld.
- res_vld is high the cycle after the final isqrt_y_vld.
- Total accept-to-res_vld: n·(L+1)+1 cycles.
- arg_rdy rises in the same cycle as res_vld, so back-to-back accept is possible on that cycle.
- Exactly one isqrt_x_vld pulse per stage and exactly n pulses per job. The isqrt unit never has more than one outstanding request.

## Test plan
- Depth 3, args[0]=21, args[1]=12, args[2]=16 -> isqrt_x sequence 16, 16, 25 -> res=5, one res_vld pulse, latency 3(L+1)+1.
- n_terms=1, args[0]=1000000 -> single isqrt_x_vld with x=1000000 -> res=1000. n_terms=0 gives the identical result. n_terms=7 (N_ARGS=3) behaves as depth 3.
- Wrap: n_terms=2, args[1]=4, args[0]=32'hFFFFFFFE -> second isqrt_x=0 (mod 2^32) -> res=0.
- Backpressure: hold arg_vld high with changing args during a job -> only the first set is used. After res_vld, a new accept occurs in the same cycle, and a stray isqrt_y_vld in IDLE is ignored.
- Reset mid-job: assert rst during WAIT of stage 2 -> arg_rdy=1, isqrt_x_vld=0, res=0 immediately. A delayed isqrt_y_vld afterwards produces no res_vld. A following job with args 21/12/16 gives res=5.
- Random latency: isqrt model with L random in 1..8 over 1000 random jobs with random depth -> res matches the reference model, and the counts of res_vld and x_vld pulses are correct.
